rtc_access_ctrl: RTL

Command-level sequencer for the V3023 RTC multiplexed AD bus, directly upstream of the bus-timing generator. Accepts register read/write commands, optionally as bursts of consecutive addresses. Per register it raises `Acceso`/`read` toward the timing generator, drives address and write data onto the AD bus during that block's valid windows, and captures read data. Completion is marked by the generator's `FRW` pulse, and a response is returned per register.

---
 rtl/rtc_pkg.sv | 17 +
 rtl/rtc_access_ctrl_if.sv | 44 ++++
 rtl/rtc_access_timer.sv | 35 +++
 rtl/rtc_access_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and defaults for the V3023 RTC access sequencer.
package rtc_pkg;

   localparam int RTC_ADDR_W          = 8;
   localparam int RTC_DATA_W          = 8;
   localparam int RTC_TIMEOUT_DEFAULT = 255;

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      DATA,
      WAIT_FRW,
      RESP
   } rtc_state_e;

endpackage

// File: rtl/rtc_access_ctrl_if.sv
// Command/response channel plus timing-generator and AD-bus signals of the RTC sequencer.
interface rtc_access_ctrl_if
   import rtc_pkg::*;
#(
   parameter int ADDR_W = RTC_ADDR_W,
   parameter int DATA_W = RTC_DATA_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_read;
   logic [ADDR_W-1:0] cmd_addr;
   logic [2:0]        cmd_len;
   logic [DATA_W-1:0] cmd_wdata;
   logic              wr_data_req;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_last;
   logic              rsp_err;
   logic              Acceso;
   logic              read;
   logic              AValid;
   logic              WValid;
   logic              RValid;
   logic              FRW;
   logic [DATA_W-1:0] ad_out;
   logic              ad_oe;
   logic [DATA_W-1:0] ad_in;

   modport slave (
      input  cmd_valid, cmd_read, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
      input  AValid, WValid, RValid, FRW, ad_in,
      output cmd_ready, wr_data_req, rsp_valid, rsp_rdata, rsp_last, rsp_err,
      output Acceso, read, ad_out, ad_oe
   );

   modport master (
      output cmd_valid, cmd_read, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
      output AValid, WValid, RValid, FRW, ad_in,
      input  cmd_ready, wr_data_req, rsp_valid, rsp_rdata, rsp_last, rsp_err,
      input  Acceso, read, ad_out, ad_oe
   );

endinterface

// File: rtl/rtc_access_timer.sv
// Clearable saturating up-counter; tc stays high once TERMINAL is reached until cleared.
module rtc_access_timer
   import rtc_pkg::*;
#(
   parameter int TERMINAL = RTC_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int              CNT_W  = $clog2(TERMINAL + 1);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && (cnt_q != TC_VAL))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/rtc_access_ctrl.sv
// V3023 RTC command sequencer: per-register Acceso/read handshake, AD-bus drive and read capture.
// Optional access watchdog enabled by defining RTC_ACCESS_TIMEOUT_EN.
//
//   state    | meaning
//   IDLE     | ready for a command
//   START    | Acceso raised, waiting for the address window
//   ADDR     | driving the register address while AValid
//   DATA     | write: drive data while WValid / read: sample ad_in on RValid
//   WAIT_FRW | data window over, waiting for the generator's done pulse
//   RESP     | response held until rsp_ready
module rtc_access_ctrl
   import rtc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = RTC_TIMEOUT_DEFAULT,
   parameter int ADDR_W         = RTC_ADDR_W,
   parameter int DATA_W         = RTC_DATA_W
) (
   input logic               clk,
   input logic               reset,
   rtc_access_ctrl_if.slave  bus
);
   rtc_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        rem_q, rem_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              read_q, read_d;
   logic              err_q, err_d;
   logic              seen_q, seen_d;

   logic              busy, tmo, win, last;
   logic              cmd_ready_o, wr_data_req_o, rsp_valid_o, rsp_last_o;
   logic              acceso_o, ad_oe_o;
   logic [DATA_W-1:0] ad_out_o, rsp_rdata_o;

   assign busy = (state_q == START) || (state_q == ADDR) ||
                 (state_q == DATA)  || (state_q == WAIT_FRW);
   assign win  = read_q ? bus.RValid : bus.WValid;
   assign last = err_q || (rem_q == 3'd0);

`ifdef RTC_ACCESS_TIMEOUT_EN
   logic tmr_clr;
   assign tmr_clr = (state_q != START) && (state_d == START);

   rtc_access_timer #(.TERMINAL(TIMEOUT_CYCLES)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (tmr_clr),
      .en    (busy),
      .tc    (tmo)
   );
`else
   logic unused_tmo_cfg;
   assign tmo            = 1'b0;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      rem_d         = rem_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      read_d        = read_q;
      err_d         = err_q;
      seen_d        = seen_q;
      cmd_ready_o   = 1'b0;
      wr_data_req_o = 1'b0;
      rsp_valid_o   = 1'b0;
      rsp_last_o    = 1'b0;
      rsp_rdata_o   = '0;
      acceso_o      = 1'b0;
      ad_oe_o       = 1'b0;
      ad_out_o      = '0;

      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (bus.cmd_valid) begin
               read_d  = bus.cmd_read;
               addr_d  = bus.cmd_addr;
               rem_d   = bus.cmd_len;
               wdata_d = bus.cmd_wdata;
               err_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            acceso_o = 1'b1;
            rdata_d  = '0;
            seen_d   = 1'b0;
            if (bus.AValid)
               state_d = ADDR;
         end
         ADDR: begin
            ad_out_o = DATA_W'(addr_q);
            ad_oe_o  = bus.AValid;
            if (!bus.AValid)
               state_d = DATA;
         end
         DATA: begin
            if (!read_q) begin
               ad_out_o = wdata_q;
               ad_oe_o  = bus.WValid;
            end else if (bus.RValid) begin
               rdata_d = bus.ad_in;
            end
            if (win)
               seen_d = 1'b1;
            // FRW can overtake the end of the data window
            if (bus.FRW)
               state_d = RESP;
            else if (seen_q && !win)
               state_d = WAIT_FRW;
         end
         WAIT_FRW: begin
            if (bus.FRW)
               state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            rsp_last_o  = last;
            rsp_rdata_o = (read_q && !err_q) ? rdata_q : '0;
            if (bus.rsp_ready) begin
               if (last) begin
                  state_d = IDLE;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  rem_d   = rem_q - 3'd1;
                  state_d = START;
                  if (!read_q) begin
                     wr_data_req_o = 1'b1;
                     wdata_d       = bus.cmd_wdata;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Watchdog abort: release the generator and report the error response
      if (busy && tmo) begin
         acceso_o = 1'b0;
         ad_oe_o  = 1'b0;
         err_d    = 1'b1;
         state_d  = RESP;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         read_q  <= 1'b0;
         err_q   <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         read_q  <= read_d;
         err_q   <= err_d;
         seen_q  <= seen_d;
      end
   end

   assign bus.cmd_ready   = cmd_ready_o;
   assign bus.wr_data_req = wr_data_req_o;
   assign bus.rsp_valid   = rsp_valid_o;
   assign bus.rsp_rdata   = rsp_rdata_o;
   assign bus.rsp_last    = rsp_last_o;
   assign bus.rsp_err     = (state_q == RESP) && err_q;
   assign bus.Acceso      = acceso_o;
   assign bus.read        = (state_q != IDLE) && read_q;
   assign bus.ad_out      = ad_out_o;
   assign bus.ad_oe       = ad_oe_o;

endmodule
